// File: rtl/csi2_pkg.sv
// Shared CSI-2 constants, header payload type, sequencer state enum and error bit indices.
package csi2_pkg;

    localparam int unsigned DATA_TYPE_W  = 6;
    localparam int unsigned WORD_COUNT_W = 16;
    localparam int unsigned VC_W         = 2;
    localparam int unsigned BYTE_CNT_W   = 17;
    localparam int unsigned ERR_W        = 4;
    localparam int unsigned PIXEL_W      = 32;

    // Short packet data types
    localparam logic [DATA_TYPE_W-1:0] DT_FS = 6'h00;
    localparam logic [DATA_TYPE_W-1:0] DT_FE = 6'h01;
    localparam logic [DATA_TYPE_W-1:0] DT_LS = 6'h02;
    localparam logic [DATA_TYPE_W-1:0] DT_LE = 6'h03;

    // Long packet data type range, inclusive
    localparam logic [DATA_TYPE_W-1:0] DT_LONG_MIN = 6'h10;
    localparam logic [DATA_TYPE_W-1:0] DT_LONG_MAX = 6'h37;

    // Sticky error flag positions
    localparam int unsigned ERR_LENGTH      = 0;
    localparam int unsigned ERR_IDLE_PACKET = 1;
    localparam int unsigned ERR_FS_IN_FRAME = 2;
    localparam int unsigned ERR_FRAME_NUM   = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_LINE  = 2'd2
    } state_t;

    typedef struct packed {
        logic [VC_W-1:0]         vc;
        logic [DATA_TYPE_W-1:0]  data_type;
        logic [WORD_COUNT_W-1:0] word_count;
    } pkt_header_t;

    function automatic logic is_long_packet(input logic [DATA_TYPE_W-1:0] dt);
        return (dt >= DT_LONG_MIN) && (dt <= DT_LONG_MAX);
    endfunction

endpackage

// File: rtl/csi2_line_checker.sv
// Counts payload bytes of the current line and flags a length mismatch against its word count.
module csi2_line_checker
    import csi2_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    count_en,
    input  logic [WORD_COUNT_W-1:0] word_count,
    output logic                    length_error_c
);

    logic [BYTE_CNT_W-1:0] byte_count;
    logic [BYTE_CNT_W-1:0] wc_ext;

    // Byte counter: cleared on every packet start, +4 per accepted payload word
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            byte_count <= '0;
        end else if (clear) begin
            byte_count <= '0;
        end else if (count_en) begin
            byte_count <= byte_count + BYTE_CNT_W'(4);
        end
    end

    // Accept a final partial word: word_count <= bytes < word_count + 4
    always_comb begin
        wc_ext         = BYTE_CNT_W'(word_count);
        length_error_c = (byte_count < wc_ext) || (byte_count >= (wc_ext + BYTE_CNT_W'(4)));
    end

endmodule

// File: rtl/csi2_frame_sequencer.sv
// CSI-2 frame/line sequencer: tracks FS/long/FE packets on one virtual channel,
// forwards line payload, counts lines and raises sticky protocol errors.
// Optional build macro CSI2_FRAME_NUMBER_CHECK_EN enables the FE frame-number check (error[3]).
module csi2_frame_sequencer
    import csi2_pkg::*;
#(
    parameter logic [1:0]  VIRTUAL_CHANNEL  = 2'd0,
    parameter int unsigned LINE_COUNT_WIDTH = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        interrupt,
    input  logic [VC_W-1:0]             virtual_channel,
    input  logic [DATA_TYPE_W-1:0]      image_data_type,
    input  logic [WORD_COUNT_W-1:0]     word_count,
    input  logic [3:0][7:0]             image_data,
    input  logic                        image_data_enable,
    input  logic                        error_clear,
    output logic                        frame_valid,
    output logic                        line_valid,
    output logic [PIXEL_W-1:0]          pixel_data,
    output logic                        pixel_enable,
    output logic [LINE_COUNT_WIDTH-1:0] line_count,
    output logic [WORD_COUNT_W-1:0]     frame_number,
    output logic [ERR_W-1:0]            error
);

    state_t                      state_q;
    state_t                      state_d;
    logic                        interrupt_q;
    logic                        pkt_start_c;
    logic                        pkt_end_c;
    logic                        vc_match_c;
    pkt_header_t                 hdr_c;
    logic [WORD_COUNT_W-1:0]     line_wc_q;
    logic                        length_error_c;

    logic                        frame_valid_d;
    logic                        line_valid_d;
    logic [LINE_COUNT_WIDTH-1:0] line_count_d;
    logic [WORD_COUNT_W-1:0]     frame_number_d;
    logic [ERR_W-1:0]            err_set_c;
    logic [ERR_W-1:0]            error_d;

    // Packet boundaries from interrupt edges; header is valid on the rising-edge cycle
    always_comb begin
        pkt_start_c = interrupt & ~interrupt_q;
        pkt_end_c   = ~interrupt & interrupt_q;
        hdr_c       = '{vc: virtual_channel, data_type: image_data_type, word_count: word_count};
        vc_match_c  = (hdr_c.vc == VIRTUAL_CHANNEL);
    end

    // Edge detector history and word count of the packet in flight
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            interrupt_q <= 1'b0;
            line_wc_q   <= '0;
        end else begin
            interrupt_q <= interrupt;
            if (pkt_start_c) begin
                line_wc_q <= hdr_c.word_count;
            end
        end
    end

    csi2_line_checker u_line_checker (
        .clock          (clock),
        .reset          (reset),
        .clear          (pkt_start_c),
        .count_en       ((state_q == ST_LINE) && image_data_enable),
        .word_count     (line_wc_q),
        .length_error_c (length_error_c)
    );

    // Next state, next output values and error set events
    always_comb begin
        state_d        = state_q;
        frame_valid_d  = frame_valid;
        line_valid_d   = line_valid;
        line_count_d   = line_count;
        frame_number_d = frame_number;
        err_set_c      = '0;

        case (state_q)
            ST_IDLE: begin
                if (pkt_start_c && vc_match_c) begin
                    case (hdr_c.data_type)
                        DT_FS: begin
                            state_d        = ST_FRAME;
                            frame_valid_d  = 1'b1;
                            frame_number_d = hdr_c.word_count;
                            line_count_d   = '0;
                        end
                        DT_FE: err_set_c[ERR_IDLE_PACKET] = 1'b1;
                        DT_LS, DT_LE: ;
                        default: begin
                            if (is_long_packet(hdr_c.data_type)) begin
                                err_set_c[ERR_IDLE_PACKET] = 1'b1;
                            end
                        end
                    endcase
                end
            end
            ST_FRAME: begin
                if (pkt_start_c && vc_match_c) begin
                    case (hdr_c.data_type)
                        DT_FS: begin
                            err_set_c[ERR_FS_IN_FRAME] = 1'b1;
                            frame_number_d             = hdr_c.word_count;
                            line_count_d               = '0;
                        end
                        DT_FE: begin
                            state_d       = ST_IDLE;
                            frame_valid_d = 1'b0;
`ifdef CSI2_FRAME_NUMBER_CHECK_EN
                            if (hdr_c.word_count != frame_number) begin
                                err_set_c[ERR_FRAME_NUM] = 1'b1;
                            end
`endif
                        end
                        DT_LS, DT_LE: ;
                        default: begin
                            if (is_long_packet(hdr_c.data_type)) begin
                                state_d      = ST_LINE;
                                line_valid_d = 1'b1;
                            end
                        end
                    endcase
                end
            end
            ST_LINE: begin
                if (pkt_end_c) begin
                    state_d                = ST_FRAME;
                    line_valid_d           = 1'b0;
                    line_count_d           = line_count + LINE_COUNT_WIDTH'(1);
                    err_set_c[ERR_LENGTH]  = length_error_c;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Set wins over a simultaneous clear
        error_d = (error & ~{ERR_W{error_clear}}) | err_set_c;
`ifndef CSI2_FRAME_NUMBER_CHECK_EN
        error_d[ERR_FRAME_NUM] = 1'b0;
`endif
    end

    // State and sequencing output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            frame_valid  <= 1'b0;
            line_valid   <= 1'b0;
            line_count   <= '0;
            frame_number <= '0;
            error        <= '0;
        end else begin
            state_q      <= state_d;
            frame_valid  <= frame_valid_d;
            line_valid   <= line_valid_d;
            line_count   <= line_count_d;
            frame_number <= frame_number_d;
            error        <= error_d;
        end
    end

    // Payload forwarding: only words received while a line is open
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pixel_enable <= 1'b0;
            pixel_data   <= '0;
        end else begin
            pixel_enable <= image_data_enable && (state_q == ST_LINE);
            if (image_data_enable && (state_q == ST_LINE)) begin
                pixel_data <= image_data;
            end
        end
    end

endmodule

// File: doc/csi2_frame_sequencer.md
CSI2_FRAME_SEQUENCER -- requirements
Module: csi2_frame_sequencer

Interface
REQ-001 SHALL have parameter VIRTUAL_CHANNEL, default 2'd0: only packets on this channel are sequenced.
REQ-002 SHALL have parameter LINE_COUNT_WIDTH, default 16: width of line_count.
REQ-003 SHALL have ports: clock  in  1  sole clock, all logic on posedge; reset  in  1  asynchronous, active-high.
REQ-004 SHALL have ports: interrupt  in  1  packet header valid; held high through any long-packet payload.
REQ-005 SHALL have ports: virtual_channel  in  2; image_data_type  in  6; word_count  in  16  (payload bytes, or frame number for FS/FE).
REQ-006 SHALL have ports: image_data  in  4x8  payload bytes; image_data_enable  in  1  qualifies image_data.
REQ-007 SHALL have ports: error_clear  in  1  clears sticky errors.
REQ-008 SHALL have ports: frame_valid  out  1; line_valid  out  1; pixel_data  out  32  ({byte3..byte0}); pixel_enable  out  1.
REQ-009 SHALL have ports: line_count  out  LINE_COUNT_WIDTH; frame_number  out  16; error  out  4  sticky flags.

Function
REQ-010 SHALL detect a packet start as the rising edge of interrupt (registered previous value), and a packet end as its falling edge.
REQ-011 SHALL ignore any packet whose virtual_channel != VIRTUAL_CHANNEL; payload never reaches pixel outputs.
REQ-012 SHALL implement FSM states IDLE, FRAME, LINE; reset state IDLE.
REQ-013 IDLE: FS (type 0x00) -> FRAME, frame_valid=1, frame_number=word_count, line_count=0.
REQ-014 FRAME: long packet (type 0x10..0x37) -> LINE, line_valid=1; FE (0x01) -> IDLE, frame_valid=0.
REQ-015 LINE: packet end -> FRAME, line_valid=0, line_count increments by 1 (wraps at 2^LINE_COUNT_WIDTH).
REQ-016 SHALL treat LS/LE (0x02/0x03) and other short types as no-ops in all states.
REQ-017 SHALL register pixel_data and pixel_enable one cycle after image_data_enable, only while in LINE.
REQ-018 SHALL count received bytes in LINE in a 17-bit counter, +4 per enabled word, cleared at packet start.
REQ-019 At LINE packet end, SHALL set error[0] if byte count < word_count or byte count >= word_count + 4.
REQ-020 SHALL set error[1] on a long packet in IDLE (packet dropped, state unchanged) and on FE in IDLE.
REQ-021 SHALL set error[2] on FS received in FRAME; restarts the frame: frame_number reloaded, line_count=0.
REQ-022 Errors SHALL be sticky until error_clear; a set event in the same cycle as error_clear wins.

Reset
REQ-023 On reset, SHALL drive state=IDLE, frame_valid=0, line_valid=0, pixel_enable=0, pixel_data=0, line_count=0, frame_number=0, error=0, byte counter=0.
REQ-024 Reset asserted mid-line SHALL drop the line immediately with no error set; the next packet is decoded from IDLE.

Configuration
REQ-025 With CSI2_FRAME_NUMBER_CHECK_EN defined, FE word_count != frame_number SHALL set error[3]; FE still returns to IDLE.
REQ-026 Without CSI2_FRAME_NUMBER_CHECK_EN, error[3] SHALL be constant 0 and no comparator is synthesized.

Structure
REQ-027 A shared package csi2_pkg SHALL hold the data-type constants (FS, FE, LS, LE, long-packet range bounds), the FSM state enum and the error bit indices.
REQ-028 A sub-module csi2_line_checker SHALL hold the byte counter and the length comparison (REQ-018/019); everything else stays in csi2_frame_sequencer.

Verification
REQ-029 FS(word_count=5), long 0x18 wc=8 (2 words 0xFEE1DEAD, 0x0D15EA5E), FE(5) -> pixel_enable 2 pulses with those data, line_count=1, frame_number=5, error=0.
REQ-030 Long packet wc=8 with only 1 enabled word -> error[0]=1; error_clear pulse -> error=0.
REQ-031 Long packet 0x18 in IDLE -> error[1]=1, pixel_enable stays 0, state remains IDLE.
REQ-032 FS(1), line, FS(2) -> error[2]=1, frame_number=2, line_count=0.
REQ-033 Packet on VC 1 during FRAME -> no pixel_enable, no state change; reset mid-LINE -> all outputs at reset values next cycle.
REQ-034 With CSI2_FRAME_NUMBER_CHECK_EN: FS(3), FE(4) -> error[3]=1; without it, error[3]=0.
